// File: rtl/seq_detect_arb.sv
// Round-robin arbiter that serialises each granted word MSB-first into a shared
// 1011 detector and reports the number of matches back with the requester id.
module seq_detect_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [CW-1:0]            rsp_count,
  input  logic                     rsp_ready,
  output logic                     det_bit,
  output logic                     det_reset,
  input  logic                     det_seq_seen
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    RESP
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  sr_q;
  logic [BW-1:0]     bit_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [IW-1:0]     id_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     ptr_d;
  logic [CW-1:0]     rsp_count_q;

  logic              gnt_found;
  logic [IW-1:0]     gnt_id;
  logic [31:0]       cand;
  logic [WIDTH-1:0]  gnt_word;

  // Search starts one past the previous winner and wraps around the requesters.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(ptr_q) + i) % 32'(NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = IW'(cand);
      end
    end
    gnt_word = req_data[32'(gnt_id)*32'(WIDTH) +: WIDTH];
    ptr_d    = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (det_seq_seen && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      ptr_q       <= '0;
      rsp_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            sr_q    <= gnt_word;
            cnt_q   <= '0;
            id_q    <= gnt_id;
            ptr_q   <= ptr_d;
            state_q <= CLR;
          end
        end
        CLR: begin
          bit_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          sr_q  <= sr_q << 1;
          cnt_q <= cnt_d;
          if (bit_q == BW'(WIDTH - 1)) begin
            state_q <= DRAIN;
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        DRAIN: begin
          cnt_q       <= cnt_d;
          rsp_count_q <= cnt_d;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant is a same-cycle decode so the pulse coincides with the IDLE cycle that captures the word.
  assign req_ready = (state_q == IDLE && reset && gnt_found) ? (NREQ'(1) << gnt_id) : '0;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_count = rsp_count_q;
  assign det_bit   = (state_q == SHIFT) & sr_q[WIDTH-1];
  assign det_reset = (state_q == CLR) | ~reset;

endmodule

// File: tb/tb_seq_detect_arb.sv
// Directed plus randomized bench for seq_detect_arb with a behavioural 1011
// detector in the loop and a CW=1 twin to exercise count saturation.
module tb_seq_detect_arb;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_count;
  logic        rsp_ready;
  logic        det_bit;
  logic        det_reset;
  logic        det_seq_seen;

  logic [3:0]  req_ready_s;
  logic        rsp_valid_s;
  logic [1:0]  rsp_id_s;
  logic [0:0]  rsp_count_s;
  logic        det_bit_s;
  logic        det_reset_s;

  int tests;
  int failed;
  int start;
  logic [3:0] hist;

  seq_detect_arb #(.NREQ(4), .WIDTH(8), .CW(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_count(rsp_count), .rsp_ready(rsp_ready), .det_bit(det_bit),
    .det_reset(det_reset), .det_seq_seen(det_seq_seen)
  );

  seq_detect_arb #(.NREQ(4), .WIDTH(8), .CW(1)) dut_sat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_s), .rsp_valid(rsp_valid_s), .rsp_id(rsp_id_s),
    .rsp_count(rsp_count_s), .rsp_ready(rsp_ready), .det_bit(det_bit_s),
    .det_reset(det_reset_s), .det_seq_seen(det_seq_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared detector: flag rises the cycle after the fourth bit of 1011.
  always @(posedge clk) begin
    if (det_reset) begin
      hist         <= 4'b0000;
      det_seq_seen <= 1'b0;
    end else begin
      hist         <= {hist[2:0], det_bit};
      det_seq_seen <= ({hist[2:0], det_bit} == 4'b1011);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int ref_count(input logic [7:0] w);
    int n = 0;
    for (int p = 0; p <= 4; p++) begin
      if (w[7-p -: 4] == 4'b1011) n++;
    end
    return (n > 15) ? 15 : n;
  endfunction

  function automatic int rr_pick(input logic [3:0] m, input int s);
    for (int k = 0; k < 4; k++) begin
      if (m[(s + k) % 4]) return (s + k) % 4;
    end
    return 0;
  endfunction

  task automatic wait_grant(input int exp_id, input bit immediate, output bit got);
    int waited = 0;
    got = 1'b0;
    #1;
    for (int c = 0; c < 30; c++) begin
      if (req_ready != 4'b0000) begin
        got = 1'b1;
        break;
      end
      chk("idle_rsp_low", rsp_valid, 1'b0);
      waited++;
      step();
    end
    if (!got) begin
      chk("grant_timeout", 0, 1);
    end else begin
      if (immediate) chk("grant_latency", waited, 0);
      chk("grant_onehot", req_ready, 4'b0001 << exp_id);
      chk("twin_grant", req_ready_s, req_ready);
      chk("grant_rsp_low", rsp_valid, 1'b0);
    end
  endtask

  task automatic txn(input int exp_id, input bit immediate, input int stall, input bit drop);
    bit got;
    logic [7:0] w;
    int ec;
    wait_grant(exp_id, immediate, got);
    if (got) begin
      w  = req_data[exp_id*8 +: 8];
      ec = ref_count(w);
      start = (exp_id + 1) % 4;
      rsp_ready = 1'b0;
      step();
      chk("clr_det_reset", det_reset, 1'b1);
      chk("clr_det_bit", det_bit, 1'b0);
      chk("clr_req_ready", req_ready, 4'b0000);
      chk("twin_clr", {det_reset_s, det_bit_s}, {det_reset, det_bit});
      if (drop) req_valid[exp_id] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        step();
        chk("shift_det_bit", det_bit, w[7-k]);
        chk("shift_det_reset", det_reset, 1'b0);
        chk("shift_req_ready", req_ready, 4'b0000);
        chk("shift_rsp_valid", rsp_valid, 1'b0);
      end
      step();
      chk("drain_det_bit", det_bit, 1'b0);
      chk("drain_det_reset", det_reset, 1'b0);
      chk("drain_rsp_valid", rsp_valid, 1'b0);
      for (int n = 0; n <= stall; n++) begin
        step();
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_id", rsp_id, exp_id);
        chk("rsp_count", rsp_count, ec);
        chk("rsp_req_ready", req_ready, 4'b0000);
        chk("rsp_count_sat", rsp_count_s, (ec > 1) ? 1 : ec);
        chk("twin_rsp_id", {rsp_valid_s, rsp_id_s}, {1'b1, 2'(exp_id)});
        if (n == stall) rsp_ready = 1'b1;
      end
      step();
      chk("rsp_release", rsp_valid, 1'b0);
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    bit got;
    int id;
    tests = 0;
    failed = 0;
    start = 0;
    reset = 1'b0;
    req_valid = 4'b0000;
    req_data = '0;
    rsp_ready = 1'b0;
    step();
    step();
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_rsp_count", rsp_count, 4'd0);
    chk("rst_det_bit", det_bit, 1'b0);
    chk("rst_det_reset", det_reset, 1'b1);
    reset = 1'b1;
    step();
    chk("idle_det_reset", det_reset, 1'b0);
    chk("idle_req_ready", req_ready, 4'b0000);

    // Fairness with all requesters pending, then wrap with only 0 and 3.
    req_data = $urandom;
    req_valid = 4'b1111;
    txn(0, 1, 0, 0);
    txn(1, 1, 0, 0);
    txn(2, 1, 0, 0);
    txn(3, 1, 0, 0);
    txn(0, 1, 0, 0);
    req_valid = 4'b1001;
    txn(3, 1, 0, 0);
    txn(0, 1, 0, 0);

    // Pattern words on requester 2.
    req_valid = 4'b0100;
    req_data[23:16] = 8'b10110000;
    txn(2, 1, 0, 1);
    req_valid[2] = 1'b1;
    req_data[23:16] = 8'b10110110;
    txn(2, 1, 0, 1);
    req_valid[2] = 1'b1;
    req_data[23:16] = 8'hFF;
    txn(2, 1, 0, 1);
    req_valid[2] = 1'b1;
    req_data[23:16] = 8'h00;
    txn(2, 1, 0, 1);
    req_valid[2] = 1'b1;
    req_data[23:16] = 8'b00000101;
    txn(2, 1, 0, 1);
    req_valid[2] = 1'b1;
    req_data[23:16] = 8'b10000000;
    txn(2, 1, 0, 1);

    // Backpressure with another requester waiting.
    req_valid = 4'b0011;
    req_data = $urandom;
    txn(0, 1, 5, 1);
    txn(1, 1, 0, 1);

    for (int r = 0; r < 12; r++) begin
      req_valid = 4'($urandom_range(1, 15));
      req_data = $urandom;
      id = rr_pick(req_valid, start);
      txn(id, 1, $urandom_range(0, 3), 1);
    end

    // Reset during the fourth SHIFT cycle of a requester 1 word.
    req_valid = 4'b0010;
    req_data = $urandom;
    wait_grant(1, 1, got);
    for (int k = 0; k < 5; k++) step();
    reset = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 4'b0000);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_rsp_id", rsp_id, 2'd0);
    chk("mid_rst_rsp_count", rsp_count, 4'd0);
    chk("mid_rst_det_bit", det_bit, 1'b0);
    chk("mid_rst_det_reset", det_reset, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("in_rst_rsp_valid", rsp_valid, 1'b0);
      chk("in_rst_req_ready", req_ready, 4'b0000);
    end
    start = 0;
    req_valid = 4'b0011;
    reset = 1'b1;
    txn(0, 1, 0, 1);
    txn(1, 1, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seq_detect_arb.md
SEQ_DETECT_ARB -- requirements
Module: seq_detect_arb

Interface
Parameters:
REQ-001 The block SHALL take parameter NREQ, default 4, as the number of requesters.
REQ-002 The block SHALL take parameter WIDTH, default 8, as the bits per request word.
REQ-003 The block SHALL take parameter CW, default 4, as the width of the match-count field.
Ports:
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low (0 = reset).
REQ-006 req_valid  input  NREQ  per-requester word-pending flag.
REQ-007 req_data  input  NREQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  NREQ  one-hot grant pulse, one cycle wide.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_id  output  clog2(NREQ)  index of the requester the result belongs to.
REQ-011 rsp_count  output  CW  number of 1011 matches in the word.
REQ-012 rsp_ready  input  1  consumer accepts the result.
REQ-013 det_bit  output  1  serial bit to the shared 1011 detector.
REQ-014 det_reset  output  1  active-high synchronous clear to the detector.
REQ-015 det_seq_seen  input  1  detector match flag; it goes high one cycle after the fourth bit of a pattern is presented; overlapping detection.

Function
REQ-016 The FSM SHALL have states IDLE, CLR, SHIFT, DRAIN and RESP.
REQ-017 IDLE: if any req_valid is high, the block SHALL grant one round-robin winner, pulse its req_ready, capture its word into the shift register, clear the counter, record the winner id, and go to CLR; otherwise it SHALL stay in IDLE.
REQ-018 Round-robin SHALL search from (last winner + 1) mod NREQ upward with wrap-around; after reset the search SHALL start at index 0.
REQ-019 CLR SHALL last one cycle with det_reset=1 and det_bit=0, then go to SHIFT; every word SHALL start from a cleared detector, so there is no history across words or requesters.
REQ-020 SHIFT SHALL last exactly WIDTH cycles and drive det_bit with the captured word MSB first, one bit per cycle, then go to DRAIN.
REQ-021 DRAIN SHALL last one cycle with det_bit=0 and det_reset=0, then go to RESP.
REQ-022 In every SHIFT and DRAIN cycle where det_seq_seen=1, the counter SHALL increment.
REQ-023 The counter SHALL saturate at 2^CW-1.
REQ-024 RESP SHALL hold rsp_valid=1 with rsp_id and rsp_count stable until a cycle with rsp_ready=1, then go to IDLE.
REQ-025 No grant SHALL occur while the FSM is outside IDLE; pending req_valid SHALL wait.
REQ-026 Latency: with the grant in cycle G, CLR SHALL occur at G+1, SHIFT at G+2..G+WIDTH+1, DRAIN at G+WIDTH+2, and rsp_valid SHALL first be high at G+WIDTH+3 (G+11 for WIDTH=8).
REQ-027 The earliest next grant SHALL be the cycle after the rsp handshake.
REQ-028 Outside SHIFT, det_bit SHALL be 0.
REQ-029 det_reset SHALL be 1 only in CLR and while reset is asserted.
REQ-030 req_ready SHALL be 0 except in a grant cycle, and SHALL never have more than one bit set.
REQ-031 All outputs SHALL be driven from registers or from state decode, with no combinational path from req_valid to rsp_*.

Reset
REQ-032 While reset=0, the block SHALL immediately (asynchronously) force state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_count=0, det_bit=0, det_reset=1, counter=0, shift register=0 and round-robin pointer=0.
REQ-033 Reset mid-operation SHALL abort the current word with no response issued.
REQ-034 The aborted requester SHALL not be re-granted automatically.
REQ-035 After reset=1, the first grant SHALL go to the lowest-indexed valid requester.

Verification
REQ-036 req_valid=0100, req_data[2]=8'b10110000, rsp_ready=1 -> req_ready=0100 for one cycle; det_bit 1,0,1,1,0,0,0,0; rsp_valid at G+11 with rsp_id=2, rsp_count=1.
REQ-037 Overlap: word 8'b10110110 -> rsp_count=2; word 8'hFF -> rsp_count=0; word 8'h00 -> rsp_count=0.
REQ-038 Isolation: word 8'b00000101 followed by word 8'b10000000 on the same requester -> both rsp_count=0 (no cross-word match).
REQ-039 Fairness: req_valid=1111 held continuously -> grant order 0,1,2,3,0.
REQ-040 Fairness after wrap: after a grant to requester 3 with only requesters 0 and 3 valid -> next grant goes to 0.
REQ-041 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_count stable; no req_ready pulse; a handshake on the 6th cycle -> IDLE on the next cycle.
REQ-042 Reset mid-word: reset=0 during the 4th SHIFT cycle of a requester 1 word -> outputs at reset values immediately, no rsp_valid; after release with req_valid=0011 -> grant to requester 0.
